// File: rtl/dpram_ctrl_pkg.sv
// rtl/dpram_ctrl_pkg.sv - shared types and default widths for the dual-port RAM access controller
package dpram_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/dpram_access_ctrl_rr_arb2.sv
// rtl/dpram_access_ctrl_rr_arb2.sv - two-way round-robin arbiter with one-hot grant
module rr_arb2
    import dpram_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_t rr_last;

    // Contention goes to whoever did not win last; a lone request always wins.
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = (rr_last == REQ_A) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Remember the most recent winner; reset to B so A wins the first contention.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= REQ_B;
        end else if (gnt[0]) begin
            rr_last <= REQ_A;
        end else if (gnt[1]) begin
            rr_last <= REQ_B;
        end
    end

endmodule

// File: rtl/dpram_access_ctrl.sv
// rtl/dpram_access_ctrl.sv - shares one RAM command port between two requesters (optional clear sweep: DPRAM_INIT_CLEAR_EN)
module dpram_access_ctrl
    import dpram_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_enb,
    output logic              ram_rd_enb,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              init_busy
);

    state_t            state;
    logic [1:0]        gnt;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;

`ifdef DPRAM_INIT_CLEAR_EN
    localparam int DEPTH = 1 << ADDR_W;
    logic [ADDR_W:0] init_cnt;
`endif

    rr_arb2 u_arb (
        .clock  (clock),
        .rst_n  (rst_n),
        .enable (state == ST_RUN),
        .req    ({b_req, a_req}),
        .gnt    (gnt)
    );

    assign a_gnt = gnt[0];
    assign b_gnt = gnt[1];

    // Select the granted requester's command fields.
    always_comb begin
        cmd_we    = gnt[1] ? b_we    : a_we;
        cmd_addr  = gnt[1] ? b_addr  : a_addr;
        cmd_wdata = gnt[1] ? b_wdata : a_wdata;
    end

    // Drive the RAM port: granted command, clear sweep, or hold the last address/data.
    always_comb begin
        ram_addr   = addr_q;
        ram_din    = din_q;
        ram_wr_enb = 1'b0;
        ram_rd_enb = 1'b0;
        if (|gnt) begin
            ram_addr   = cmd_addr;
            ram_din    = cmd_wdata;
            ram_wr_enb = cmd_we;
            ram_rd_enb = ~cmd_we;
        end
`ifdef DPRAM_INIT_CLEAR_EN
        if (state == ST_INIT) begin
            ram_addr   = init_cnt[ADDR_W-1:0];
            ram_din    = '0;
            ram_wr_enb = 1'b1;
        end
`endif
    end

    // Keep whatever was last presented so an idle port stays stable.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            addr_q <= ram_addr;
            din_q  <= ram_din;
        end
    end

    // Sequence HOLD -> (INIT) -> RUN; RUN persists until the next reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HOLD;
        end else begin
            case (state)
`ifdef DPRAM_INIT_CLEAR_EN
                ST_HOLD: state <= ST_INIT;
                ST_INIT: if (init_cnt == (ADDR_W+1)'(DEPTH - 1)) state <= ST_RUN;
`else
                ST_HOLD: state <= ST_RUN;
`endif
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_HOLD;
            endcase
        end
    end

`ifdef DPRAM_INIT_CLEAR_EN
    // Sweep address counter, one location per cycle while clearing.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end else begin
            init_cnt <= '0;
        end
    end

    assign init_busy = (state == ST_INIT);
`else
    assign init_busy = 1'b0;
`endif

    // Tag read returns to their owner; RAM data lands one cycle after the grant.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= gnt[0] & ~a_we;
            b_rvalid <= gnt[1] & ~b_we;
        end
    end

    assign a_rdata = a_rvalid ? ram_dout : '0;
    assign b_rdata = b_rvalid ? ram_dout : '0;

endmodule
